// File: rtl/ariele_pkg.sv
// Shared types for the ariele slave memory: FSM states, LFSR taps, response entry layout
// and the self-initialisation pattern.
package ariele_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Entry fields are sized for the widest supported configuration (DATA_W <= 64, RESP_LAT <= 255)
  localparam int RESP_MAX_DW = 64;
  localparam int AGE_W       = 8;

  typedef struct packed {
    logic [RESP_MAX_DW-1:0] data;
    logic [AGE_W-1:0]       age;
  } resp_entry_t;

  // Word p of slave snum holds (snum << (data_w-2)) + (p << 2); the caller truncates to data_w
  function automatic logic [RESP_MAX_DW-1:0] init_pattern(input int snum, input int data_w,
                                                          input logic [31:0] idx);
    logic [RESP_MAX_DW-1:0] hi;
    hi = RESP_MAX_DW'(snum) << (data_w - 2);
    return hi + (RESP_MAX_DW'(idx) << 2);
  endfunction

endpackage

// File: rtl/ariele_resp_fifo.sv
// Outstanding-read FIFO: every stored entry carries a saturating age; the head is offered
// once it is old enough. With LAT==1 an incoming entry into an empty FIFO is offered directly.
module ariele_resp_fifo
  import ariele_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              take,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [AGE_W-1:0] AGE_PUSH = AGE_W'(1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LAT);
  localparam logic [AGE_W-1:0] AGE_POP  = AGE_W'(LAT - 1);

  logic [DATA_W-1:0] data_reg [DEPTH];
  logic [AGE_W-1:0]  age_reg  [DEPTH];
  logic [AGE_W-1:0]  age_next [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  resp_entry_t       head;
  logic              bypass, do_store, do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));

  always_comb begin
    head.data = RESP_MAX_DW'(data_reg[rd_ptr_reg]);
    head.age  = age_reg[rd_ptr_reg];
  end

  // An entry pushed this cycle is already one cycle old when it is first seen in storage
  assign bypass    = empty & push & (LAT == 1);
  assign out_valid = bypass | (~empty & (head.age >= AGE_POP));
  assign out_data  = empty ? push_data : head.data[DATA_W-1:0];
  assign do_pop    = take & out_valid & ~empty;
  assign do_store  = push & ~full & ~(bypass & take);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_store) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)   rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_store) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_store) data_reg[wr_ptr_reg] <= push_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_next[gi] = (do_store && wr_ptr_reg == PTR_W'(gi)) ? AGE_PUSH :
                            (age_reg[gi] < AGE_MAX) ? age_reg[gi] + 1'b1 : age_reg[gi];
    end
    if (DATA_W < RESP_MAX_DW) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^head.data[RESP_MAX_DW-1:DATA_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) age_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) age_reg[i] <= age_next[i];
    end
  end

endmodule

// File: rtl/ariele_slave_mem.sv
// Self-initialising xbar slave memory with fixed read latency and bounded outstanding reads.
// Optional random ack/resp stalls are enabled by defining ARIELE_SLAVE_RANDSTALL_EN.
module ariele_slave_mem
  import ariele_pkg::*;
#(
  parameter int SNUM       = 0,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEMSIZE    = 1024,
  parameter int RESP_LAT   = 1,
  parameter int RESP_DEPTH = 4,
  parameter int RAND_SEED  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  output logic              ack_o,
  input  logic [ADDR_W-1:0] addr_bi,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_bi,
  output logic              resp_o,
  output logic [DATA_W-1:0] rdata_bo,
  output logic              init_done_o,
  output logic              rdfifo_full_o
);

  localparam int IDX_W = $clog2(MEMSIZE);

  logic [DATA_W-1:0]      mem [MEMSIZE];
  fsm_state_t             state_reg, state_next;
  logic [IDX_W-1:0]       init_ptr_reg, init_ptr_next;
  logic                   init_done_reg, init_done_next;
  logic                   resp_reg;
  logic [DATA_W-1:0]      rdata_reg;

  logic                   run, ack_stall, resp_stall;
  logic                   fifo_full, fifo_empty, out_valid, take, rd_push;
  logic [DATA_W-1:0]      out_data, rd_word;
  logic [IDX_W-1:0]       idx;
  logic [RESP_MAX_DW-1:0] init_word;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_waddr;
  logic [DATA_W-1:0]      mem_wdata;

  assign idx = addr_bi[2 +: IDX_W];
  assign run = (state_reg == ST_RUN);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg     <= ST_INIT;
      init_ptr_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_ptr_reg  <= init_ptr_next;
      init_done_reg <= init_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    init_ptr_next  = init_ptr_reg;
    init_done_next = init_done_reg;
    case (state_reg)
      ST_INIT: begin
        init_ptr_next = init_ptr_reg + 1'b1;
        if (init_ptr_reg == IDX_W'(MEMSIZE - 1)) begin
          state_next     = ST_RUN;
          init_done_next = 1'b1;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  // Writes never need a FIFO slot, so only reads are held off by a full FIFO
  assign ack_o   = req_i & run & ~ack_stall & (we_i | ~fifo_full);
  assign rd_push = ack_o & ~we_i;

  assign init_word = init_pattern(SNUM, DATA_W, 32'(init_ptr_reg));
  assign mem_we    = ~run | (ack_o & we_i);
  assign mem_waddr = run ? idx : init_ptr_reg;
  assign mem_wdata = run ? wdata_bi : init_word[DATA_W-1:0];

  always_ff @(posedge clk_i) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_word = mem[idx];

  ariele_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH),
    .LAT    (RESP_LAT)
  ) u_resp_fifo (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .push      (rd_push),
    .push_data (rd_word),
    .take      (take),
    .out_valid (out_valid),
    .out_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign take = out_valid & ~resp_stall;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      resp_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      resp_reg <= take;
      if (take) rdata_reg <= out_data;
    end
  end

  assign resp_o        = resp_reg;
  assign rdata_bo      = rdata_reg;
  assign init_done_o   = init_done_reg;
  assign rdfifo_full_o = fifo_full;

`ifdef ARIELE_SLAVE_RANDSTALL_EN
  logic [15:0] lfsr_reg;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr_reg <= 16'(RAND_SEED);
    else if (run) lfsr_reg <= {lfsr_reg[14:0], ^(lfsr_reg & LFSR_TAPS)};
  end

  assign ack_stall  = (lfsr_reg[1:0] == 2'b00);
  assign resp_stall = (lfsr_reg[3:2] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = (RAND_SEED != 0);
  assign ack_stall   = 1'b0;
  assign resp_stall  = 1'b0;
`endif

  logic unused_sig;
  generate
    if (ADDR_W > 2 + IDX_W) begin : g_addr_hi
      assign unused_sig = ^{addr_bi[ADDR_W-1:2+IDX_W], addr_bi[1:0], fifo_empty, init_word};
    end else begin : g_addr_lo
      assign unused_sig = ^{addr_bi[1:0], fifo_empty, init_word};
    end
  endgenerate

endmodule
